// File: rtl/pio_fifo_pair.sv
// TX/RX word FIFO pair between the system bus and the PIO machine. Either
// direction can borrow the other's storage to double its depth.
// Levels are 4 bits wide, so DEPTH may be at most 7.

module pio_fifo_ctl #(
  parameter int PW = 3,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [LW-1:0] cap,
  input  logic          wr,
  input  logic          rd,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;

  // Zero capacity falls out naturally as full and empty at once.
  assign full   = (lvl_q >= cap);
  assign empty  = (lvl_q == '0);
  assign wr_ok  = wr & ~full  & ~flush;
  assign rd_ok  = rd & ~empty & ~flush;
  assign wr_ptr = wp_q;
  assign rd_ptr = rp_q;
  assign level  = lvl_q;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p,
                                         input logic [LW-1:0] c);
    return (LW'(p) + LW'(1) >= c) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    lvl_d = lvl_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      lvl_d = '0;
    end else begin
      if (wr_ok) wp_d = bump(wp_q, cap);
      if (rd_ok) rp_d = bump(rp_q, cap);
      unique case ({wr_ok, rd_ok})
        2'b10:   lvl_d = lvl_q + LW'(1);
        2'b01:   lvl_d = lvl_q - LW'(1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
    end
  end
endmodule

module pio_fifo_pair #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        join_tx,
  input  logic        join_rx,
  input  logic        tx_wr,
  input  logic [31:0] tx_wdata,
  input  logic        rx_rd,
  output logic [31:0] rx_rdata,
  input  logic        mach_pull,
  output logic [31:0] mach_din,
  output logic        mach_empty,
  input  logic        mach_push,
  input  logic [31:0] mach_dout,
  output logic        mach_full,
  output logic [3:0]  tx_level,
  output logic [3:0]  rx_level,
  output logic        tx_full,
  output logic        tx_empty,
  output logic        rx_full,
  output logic        rx_empty,
  output logic        tx_over,
  output logic        rx_under,
  input  logic [1:0]  flag_clr
);
  localparam int PW = $clog2(2*DEPTH);
  localparam int LW = 4;

  // Shared storage: TX owns the low half, RX the high half; a joined FIFO
  // owns all of it while the other direction has zero capacity.
  logic [31:0]   mem_q [2*DEPTH];
  logic [1:0]    join_q;
  logic          jt, jr, flush;
  logic [LW-1:0] tx_cap, rx_cap;
  logic [PW-1:0] rx_base, tx_wp, tx_rp, rx_wp, rx_rp;
  logic          tx_wr_ok, tx_rd_ok, rx_wr_ok, rx_rd_ok;
  logic          tx_over_q, tx_over_d, rx_under_q, rx_under_d;

  assign jt      = join_q[1] & ~join_q[0];
  assign jr      = join_q[0] & ~join_q[1];
  assign flush   = ({join_tx, join_rx} != join_q);
  assign tx_cap  = jr ? '0 : (jt ? LW'(2*DEPTH) : LW'(DEPTH));
  assign rx_cap  = jt ? '0 : (jr ? LW'(2*DEPTH) : LW'(DEPTH));
  assign rx_base = jr ? '0 : PW'(DEPTH);

  pio_fifo_ctl #(.PW(PW), .LW(LW)) u_tx (
    .clk(clk), .reset(reset), .flush(flush), .cap(tx_cap),
    .wr(tx_wr), .rd(mach_pull), .wr_ok(tx_wr_ok), .rd_ok(tx_rd_ok),
    .wr_ptr(tx_wp), .rd_ptr(tx_rp), .level(tx_level),
    .full(tx_full), .empty(tx_empty)
  );

  pio_fifo_ctl #(.PW(PW), .LW(LW)) u_rx (
    .clk(clk), .reset(reset), .flush(flush), .cap(rx_cap),
    .wr(mach_push), .rd(rx_rd), .wr_ok(rx_wr_ok), .rd_ok(rx_rd_ok),
    .wr_ptr(rx_wp), .rd_ptr(rx_rp), .level(rx_level),
    .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk) begin
    if (tx_wr_ok) mem_q[tx_wp]           <= tx_wdata;
    if (rx_wr_ok) mem_q[rx_base + rx_wp] <= mach_dout;
  end

  assign mach_din   = tx_empty ? 32'h0 : mem_q[tx_rp];
  assign rx_rdata   = rx_empty ? 32'h0 : mem_q[rx_base + rx_rp];
  assign mach_empty = tx_empty;
  assign mach_full  = rx_full;

  // Set dominates clear; a zero-capacity FIFO never raises its flag.
  always_comb begin
    tx_over_d  = (tx_over_q  & ~flag_clr[0]) |
                 (tx_wr & tx_full & (tx_cap != '0) & ~flush);
    rx_under_d = (rx_under_q & ~flag_clr[1]) |
                 (rx_rd & rx_empty & (rx_cap != '0) & ~flush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      join_q     <= {join_tx, join_rx};
      tx_over_q  <= 1'b0;
      rx_under_q <= 1'b0;
    end else begin
      join_q     <= {join_tx, join_rx};
      tx_over_q  <= tx_over_d;
      rx_under_q <= rx_under_d;
    end
  end

  assign tx_over  = tx_over_q;
  assign rx_under = rx_under_q;

  // tx_rd_ok / rx_rd_ok only advance pointers inside the controllers.
  logic unused_ok;
  assign unused_ok = tx_rd_ok ^ rx_rd_ok;
endmodule

// File: tb/tb_pio_fifo_pair.sv
// Directed bench for pio_fifo_pair: unjoined, joined and flush behaviour.
module tb_pio_fifo_pair;
  logic        clk = 1'b0;
  logic        reset, join_tx, join_rx, tx_wr, rx_rd, mach_pull, mach_push;
  logic [31:0] tx_wdata, mach_dout, rx_rdata, mach_din;
  logic        mach_empty, mach_full, tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_over, rx_under;
  logic [3:0]  tx_level, rx_level;
  logic [1:0]  flag_clr;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pio_fifo_pair #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .join_tx(join_tx), .join_rx(join_rx),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .rx_rd(rx_rd), .rx_rdata(rx_rdata),
    .mach_pull(mach_pull), .mach_din(mach_din), .mach_empty(mach_empty),
    .mach_push(mach_push), .mach_dout(mach_dout), .mach_full(mach_full),
    .tx_level(tx_level), .rx_level(rx_level), .tx_full(tx_full),
    .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .tx_over(tx_over), .rx_under(rx_under), .flag_clr(flag_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One cycle of strobes, then all strobes back to idle.
  task automatic cyc(input logic tw, input logic [31:0] td, input logic mp,
                     input logic mpu, input logic [31:0] md, input logic rr,
                     input logic [1:0] fc);
    tx_wr = tw; tx_wdata = td; mach_pull = mp;
    mach_push = mpu; mach_dout = md; rx_rd = rr; flag_clr = fc;
    tick();
    tx_wr = 0; mach_pull = 0; mach_push = 0; rx_rd = 0; flag_clr = 0;
  endtask

  task automatic wr_tx(input logic [31:0] d); cyc(1, d, 0, 0, 0, 0, 0); endtask
  task automatic pull();                      cyc(0, 0, 1, 0, 0, 0, 0); endtask
  task automatic push(input logic [31:0] d);  cyc(0, 0, 0, 1, d, 0, 0); endtask
  task automatic rd_rx();                     cyc(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic clr(input logic [1:0] c);    cyc(0, 0, 0, 0, 0, 0, c); endtask

  initial begin
    reset = 1; join_tx = 0; join_rx = 0; tx_wr = 0; tx_wdata = 0; rx_rd = 0;
    mach_pull = 0; mach_push = 0; mach_dout = 0; flag_clr = 0;
    tick(); tick();
    reset = 0; tick();
    check("rst_txlvl", tx_level, 0);   check("rst_rxlvl", rx_level, 0);
    check("rst_txe", tx_empty, 1);     check("rst_rxe", rx_empty, 1);
    check("rst_txf", tx_full, 0);      check("rst_rxf", rx_full, 0);
    check("rst_over", tx_over, 0);     check("rst_under", rx_under, 0);
    check("rst_din", mach_din, 0);     check("rst_rdata", rx_rdata, 0);

    // Fill TX, overflow, drain.
    wr_tx(32'hA);
    check("fwft_head", mach_din, 32'hA); check("lvl1", tx_level, 1);
    wr_tx(32'hB); wr_tx(32'hC);
    check("txf_at3", tx_full, 0);
    wr_tx(32'hD);
    check("tx_lvl4", tx_level, 4); check("tx_full4", tx_full, 1);
    wr_tx(32'hE);
    check("tx_over_set", tx_over, 1); check("tx_lvl_drop", tx_level, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pull%0d", i), mach_din, 32'hA + i);
      pull();
    end
    check("mach_empty", mach_empty, 1); check("din_zero", mach_din, 0);
    pull();
    check("pull_empty_lvl", tx_level, 0);
    check("over_hold", tx_over, 1);
    clr(2'b01);
    check("over_clr", tx_over, 0);

    // Simultaneous write and pull, including at full (pointers wrap here).
    wr_tx(32'h1); wr_tx(32'h2);
    cyc(1, 32'h9, 1, 0, 0, 0, 0);
    check("sim_lvl", tx_level, 2); check("sim_head", mach_din, 32'h2);
    wr_tx(32'h10); wr_tx(32'h11);
    check("sim_full", tx_full, 1);
    cyc(1, 32'h12, 1, 0, 0, 0, 0);
    check("simf_lvl", tx_level, 3); check("simf_over", tx_over, 1);
    check("simf_head", mach_din, 32'h9);
    pull(); check("drain1", mach_din, 32'h10);
    pull(); check("drain2", mach_din, 32'h11);
    pull(); check("drain_e", tx_empty, 1);
    clr(2'b01);

    // RX underflow flag and set-wins-over-clear.
    rd_rx();
    check("under_set", rx_under, 1);
    clr(2'b10);
    check("under_clr", rx_under, 0);
    cyc(0, 0, 0, 0, 0, 1, 2'b10);
    check("under_setwins", rx_under, 1);
    clr(2'b10);

    // RX fill/overflow/drain.
    for (int i = 0; i < 4; i++) push(32'h71 + i);
    check("rx_full", mach_full, 1); check("rx_lvl4", rx_level, 4);
    push(32'h75);
    check("rx_drop_lvl", rx_level, 4); check("rx_no_under", rx_under, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rxrd%0d", i), rx_rdata, 32'h71 + i);
      rd_rx();
    end
    check("rx_empty", rx_empty, 1); check("rdata_zero", rx_rdata, 0);

    // join_rx flush with push on the flush cycle, then 8-deep RX.
    push(32'h31); push(32'h32); push(32'h33);
    check("rx_lvl3", rx_level, 3);
    join_rx = 1;
    push(32'hEE);
    check("flush_lvl", rx_level, 0); check("flush_e", rx_empty, 1);
    check("jrx_txf", tx_full, 1); check("jrx_txe", tx_empty, 1);
    wr_tx(32'h44);
    check("cap0_lvl", tx_level, 0); check("cap0_noover", tx_over, 0);
    for (int i = 0; i < 7; i++) push(32'h100 + i);
    check("jrx_nf7", rx_full, 0);
    push(32'h107);
    check("jrx_lvl8", rx_level, 8); check("jrx_full", mach_full, 1);
    check("jrx_head", rx_rdata, 32'h100);
    join_rx = 0; tick();
    check("unjrx_flush", rx_level, 0);

    // join_tx: 8-deep TX, RX forced to zero capacity.
    join_tx = 1; tick();
    for (int i = 1; i <= 7; i++) wr_tx(i);
    check("jtx_nf7", tx_full, 0);
    wr_tx(8);
    check("jtx_lvl8", tx_level, 8); check("jtx_full", tx_full, 1);
    check("jtx_rxf", rx_full, 1); check("jtx_rxe", rx_empty, 1);
    push(32'h55);
    check("jtx_rxlvl", rx_level, 0);
    rd_rx();
    check("jtx_nounder", rx_under, 0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("jtx_pull%0d", i), mach_din, i);
      pull();
    end
    check("jtx_empty", tx_empty, 1);

    // Both joins high acts as unjoined.
    join_rx = 1; tick();
    for (int i = 0; i < 5; i++) wr_tx(32'h60 + i);
    check("both_lvl", tx_level, 4); check("both_over", tx_over, 1);
    check("both_head", mach_din, 32'h60);
    join_tx = 0; join_rx = 0; tick();
    check("both_flush", tx_level, 0);

    // Reset mid-stream with strobes active.
    push(32'h81); push(32'h82); wr_tx(32'h91); wr_tx(32'h92);
    check("pre_rx", rx_level, 2);
    reset = 1;
    cyc(1, 32'h93, 1, 1, 32'h83, 1, 0);
    reset = 0;
    check("mr_txlvl", tx_level, 0);  check("mr_rxlvl", rx_level, 0);
    check("mr_over", tx_over, 0);    check("mr_under", rx_under, 0);
    check("mr_din", mach_din, 0);    check("mr_rdata", rx_rdata, 0);
    check("mr_txe", tx_empty, 1);    check("mr_rxf", rx_full, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
